// File: rtl/alu_seq_pkg.sv
// Op codes, FSM state encoding and op-class helpers for the sequential ALU.
package alu_seq_pkg;

    localparam int unsigned OP_W = 5;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND   = 5'd0;
    localparam op_t OP_OR    = 5'd1;
    localparam op_t OP_ADD   = 5'd2;
    localparam op_t OP_SUB   = 5'd3;
    localparam op_t OP_XOR   = 5'd4;
    localparam op_t OP_NOR   = 5'd5;
    localparam op_t OP_SLL   = 5'd6;
    localparam op_t OP_SRL   = 5'd7;
    localparam op_t OP_SRA   = 5'd8;
    localparam op_t OP_ROTL  = 5'd9;
    localparam op_t OP_ROTR  = 5'd10;
    localparam op_t OP_SLT   = 5'd11;
    localparam op_t OP_SLTU  = 5'd12;
    localparam op_t OP_SGT   = 5'd13;
    localparam op_t OP_SEB   = 5'd14;
    localparam op_t OP_SEH   = 5'd15;
    localparam op_t OP_LUI   = 5'd16;
    localparam op_t OP_MFHI  = 5'd17;
    localparam op_t OP_MFLO  = 5'd18;
    localparam op_t OP_MTHI  = 5'd19;
    localparam op_t OP_MTLO  = 5'd20;
    localparam op_t OP_MULT  = 5'd21;
    localparam op_t OP_MULTU = 5'd22;
    localparam op_t OP_MADD  = 5'd23;
    localparam op_t OP_MADDU = 5'd24;
    localparam op_t OP_MSUB  = 5'd25;
    localparam op_t OP_MSUBU = 5'd26;
    localparam op_t OP_DIV   = 5'd27;
    localparam op_t OP_DIVU  = 5'd28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Multi-cycle ops that go through the muldiv iterator
    function automatic logic is_long(op_t op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_div(op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Long ops whose operands are treated as two's complement
    function automatic logic is_signed_long(op_t op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with sign fix and Hi/Lo accumulate.
module muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic             last_c,
    output logic             div0,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned P_W   = 2 * WIDTH;

    // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [P_W-1:0]   p_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;
    op_t              op_q;
    logic             neg_lo_q;
    logic             neg_hi_q;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [P_W-1:0]   p_next;
    logic [P_W-1:0]   prod_s;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Operand magnitudes and signs for signed ops
    always_comb begin
        sa    = is_signed_long(op) & a[WIDTH-1];
        sb    = is_signed_long(op) & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // One multiply or divide step per RUN cycle
    always_comb begin
        mul_sum  = {1'b0, p_q[P_W-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        rem_sh   = {p_q[P_W-1:WIDTH], p_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        if (is_div(op_q)) begin
            if (rem_diff[WIDTH])
                p_next = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            else
                p_next = {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            p_next = {mul_sum, p_q[WIDTH-1:1]};
        end
    end

    // Operand latch at start, iteration while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            op_q     <= OP_AND;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0     <= 1'b0;
        end else if (start) begin
            p_q      <= is_div(op) ? {WIDTH'(0), mag_a} : {WIDTH'(0), mag_b};
            m_q      <= is_div(op) ? mag_b : mag_a;
            cnt_q    <= CNT_W'(WIDTH - 1);
            op_q     <= op;
            neg_lo_q <= sa ^ sb;
            neg_hi_q <= sa;
            div0     <= is_div(op) && (b == '0);
        end else if (run) begin
            p_q   <= p_next;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_c = run && (cnt_q == '0);

    // Sign fix and Hi/Lo combine, consumed in FIN
    always_comb begin
        prod_s       = neg_lo_q ? -p_q : p_q;
        quo          = p_q[WIDTH-1:0];
        rem          = p_q[P_W-1:WIDTH];
        {hi_c, lo_c} = prod_s;
        case (op_q)
            OP_MADD, OP_MADDU: {hi_c, lo_c} = {hi, lo} + prod_s;
            OP_MSUB, OP_MSUBU: {hi_c, lo_c} = {hi, lo} - prod_s;
            OP_DIV, OP_DIVU: begin
                hi_c = neg_hi_q ? -rem : rem;
                lo_c = neg_lo_q ? -quo : quo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Clocked EX-stage ALU: single-cycle short ops plus iterative mul/div owning Hi/Lo.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CTRL_W  = 5,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [CTRL_W-1:0] ALUControl,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic [WIDTH-1:0]  ALUResult,
    output logic              Zero,
    output logic              Busy,
    output logic              Done,
    output logic              DivByZero,
    output logic [WIDTH-1:0]  Hi,
    output logic [WIDTH-1:0]  Lo
);

    localparam int unsigned HALF = WIDTH / 2;

    op_t                op;
    logic [SHAMT_W-1:0] shamt;
    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   short_res;
    logic [WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               done_d;
    logic               dbz_d;
    logic               busy_d;
    logic               mstart_c;
    logic               run_c;
    logic               last_c;
    logic               div0;
    logic [WIDTH-1:0]   md_hi_c;
    logic [WIDTH-1:0]   md_lo_c;

    assign op    = OP_W'(ALUControl);
    assign shamt = A[SHAMT_W-1:0];
    assign run_c = (state_q == S_RUN);
    assign Zero  = (ALUResult == '0);

    // Single-cycle op result
    always_comb begin
        short_res = '0;
        case (op)
            OP_AND:  short_res = A & B;
            OP_OR:   short_res = A | B;
            OP_ADD:  short_res = A + B;
            OP_SUB:  short_res = A - B;
            OP_XOR:  short_res = A ^ B;
            OP_NOR:  short_res = ~(A | B);
            OP_SLL:  short_res = B << shamt;
            OP_SRL:  short_res = B >> shamt;
            OP_SRA:  short_res = $signed(B) >>> shamt;
            OP_ROTL: short_res = (B << shamt) | (B >> (WIDTH - 32'(shamt)));
            OP_ROTR: short_res = (B >> shamt) | (B << (WIDTH - 32'(shamt)));
            OP_SLT:  short_res = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: short_res = WIDTH'(A < B);
            OP_SGT:  short_res = WIDTH'($signed(A) > $signed(B));
            OP_SEB:  short_res = {{(WIDTH-8){B[7]}}, B[7:0]};
            OP_SEH:  short_res = {{(WIDTH-16){B[15]}}, B[15:0]};
            OP_LUI:  short_res = {B[HALF-1:0], HALF'(0)};
            OP_MFHI: short_res = Hi;
            OP_MFLO: short_res = Lo;
            OP_MTHI: short_res = A;
            OP_MTLO: short_res = A;
            default: short_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state; divide by zero bypasses RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start && is_long(op))
                    state_d = (is_div(op) && (B == '0)) ? S_FIN : S_RUN;
            end
            S_RUN:   if (last_c) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        result_d = ALUResult;
        hi_d     = Hi;
        lo_d     = Lo;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        mstart_c = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (is_long(op)) begin
                        mstart_c = 1'b1;
                    end else begin
                        result_d = short_res;
                        done_d   = 1'b1;
                        if (op == OP_MTHI) hi_d = A;
                        if (op == OP_MTLO) lo_d = A;
                    end
                end
            end
            S_FIN: begin
                done_d = 1'b1;
                if (div0) begin
                    dbz_d    = 1'b1;
                    result_d = Lo;
                end else begin
                    hi_d     = md_hi_c;
                    lo_d     = md_lo_c;
                    result_d = md_lo_c;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ALUResult <= '0;
            Hi        <= '0;
            Lo        <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            ALUResult <= result_d;
            Hi        <= hi_d;
            Lo        <= lo_d;
            Busy      <= busy_d;
            Done      <= done_d;
            DivByZero <= dbz_d;
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (Clk),
        .rst    (Reset),
        .start  (mstart_c),
        .run    (run_c),
        .op     (op),
        .a      (A),
        .b      (B),
        .hi     (Hi),
        .lo     (Lo),
        .last_c (last_c),
        .div0   (div0),
        .hi_c   (md_hi_c),
        .lo_c   (md_lo_c)
    );

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed table-driven bench for alu_seq_muldiv plus multi-cycle corner sequences.
module tb_alu_seq_muldiv;
    import alu_seq_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [4:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic        dbz;
    } vec_t;

    vec_t vecs[$];

    alu_seq_muldiv #(
        .WIDTH   (32),
        .CTRL_W  (5),
        .SHAMT_W (5)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Busy       (Busy),
        .Done       (Done),
        .DivByZero  (DivByZero),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] hi, input logic [31:0] lo,
                       input int lat, input logic dbz);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.hi = hi; v.lo = lo; v.lat = lat; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bcnt;
        Start = 1'b1; ALUControl = v.op; A = v.a; B = v.b;
        tick();
        Start = 1'b0; A = ~v.a; B = ~v.b;
        lat = 1;
        bcnt = 0;
        while (!Done && lat < 200) begin
            if (Busy) bcnt++;
            tick();
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d busy_cycles", idx), 64'(bcnt), 64'(v.lat - 1));
        chk($sformatf("v%0d busy_at_done", idx), 64'(Busy), 64'(0));
        chk($sformatf("v%0d result", idx), 64'(ALUResult), 64'(v.res));
        chk($sformatf("v%0d zero", idx), 64'(Zero), 64'(v.res == 32'd0));
        chk($sformatf("v%0d hi", idx), 64'(Hi), 64'(v.hi));
        chk($sformatf("v%0d lo", idx), 64'(Lo), 64'(v.lo));
        chk($sformatf("v%0d divbyzero", idx), 64'(DivByZero), 64'(v.dbz));
        tick();
        chk($sformatf("v%0d done_pulse", idx), 64'(Done), 64'(0));
    endtask

    initial begin
        int c;
        int dcnt;
        vec_t fresh;

        Reset = 1'b1; Start = 1'b0; ALUControl = '0; A = '0; B = '0;

        //    op         A             B             result        Hi            Lo          lat dbz
        add(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 1'b0);
        add(OP_MADD,  32'h00000002, 32'h00000003, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 1'b0);
        add(OP_MSUB,  32'h00000002, 32'h00000003, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 1'b0);
        add(OP_MSUBU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFEC, 32'hFFFFFFFE, 32'hFFFFFFEC, 34, 1'b0);
        add(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFED, 32'hFFFFFFFC, 32'hFFFFFFED, 34, 1'b0);
        add(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
        add(OP_DIVU,  32'h00000005, 32'h00000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD,  2, 1'b1);
        add(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 34, 1'b0);
        add(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 34, 1'b0);
        add(OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 32'h0FFFFFFF, 34, 1'b0);
        add(OP_MTHI,  32'h11112222, 32'h00000000, 32'h11112222, 32'h11112222, 32'h0FFFFFFF,  1, 1'b0);
        add(OP_MTLO,  32'h33334444, 32'h00000000, 32'h33334444, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_MFHI,  32'h00000000, 32'h00000000, 32'h11112222, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_MFLO,  32'h00000000, 32'h00000000, 32'h33334444, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SRA,   32'h00000004, 32'h80000000, 32'hF8000000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_ROTR,  32'h00000008, 32'h12345678, 32'h78123456, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_ROTL,  32'h00000008, 32'h12345678, 32'h34567812, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_ROTL,  32'h00000000, 32'h12345678, 32'h12345678, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_ROTR,  32'h00000020, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SLL,   32'h00000004, 32'h0000000F, 32'h000000F0, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SRL,   32'h00000004, 32'hF0000000, 32'h0F000000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SGT,   32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SGT,   32'h00000005, 32'h00000005, 32'h00000000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SEB,   32'h00000000, 32'h00000080, 32'hFFFFFF80, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SEH,   32'h00000000, 32'h00007FFF, 32'h00007FFF, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_SEH,   32'h00000000, 32'h00008000, 32'hFFFF8000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(OP_LUI,   32'h00000000, 32'h0000ABCD, 32'hABCD0000, 32'h11112222, 32'h33334444,  1, 1'b0);
        add(5'd31,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h11112222, 32'h33334444,  1, 1'b0);

        // Reset state
        tick();
        tick();
        chk("reset result", 64'(ALUResult), 64'(0));
        chk("reset hi", 64'(Hi), 64'(0));
        chk("reset lo", 64'(Lo), 64'(0));
        chk("reset busy", 64'(Busy), 64'(0));
        chk("reset done", 64'(Done), 64'(0));
        chk("reset divbyzero", 64'(DivByZero), 64'(0));
        chk("reset zero", 64'(Zero), 64'(1));
        @(negedge Clk);
        Reset = 1'b0;
        #1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Start accepted on the cycle Done is visible
        Start = 1'b1; ALUControl = OP_MULT; A = 32'd3; B = 32'd5;
        tick();
        Start = 1'b0;
        c = 1;
        while (!Done && c < 200) begin tick(); c++; end
        chk("b2b mult latency", 64'(c), 64'(34));
        Start = 1'b1; ALUControl = OP_ADD; A = 32'd1; B = 32'd2;
        tick();
        Start = 1'b0;
        chk("b2b add done", 64'(Done), 64'(1));
        chk("b2b add result", 64'(ALUResult), 64'(3));
        chk("b2b hilo", {Hi, Lo}, 64'd15);

        // Start while busy is ignored and in-flight operands are kept
        Start = 1'b1; ALUControl = OP_MULTU; A = 32'd7; B = 32'd9;
        tick();
        Start = 1'b0;
        c = 1;
        while (!Done && c < 200) begin
            if (c == 5) begin
                Start = 1'b1; ALUControl = OP_MULT; A = 32'd100; B = 32'd100;
            end else begin
                Start = 1'b0;
            end
            tick();
            c++;
        end
        Start = 1'b0;
        chk("ignored-start latency", 64'(c), 64'(34));
        chk("ignored-start hilo", {Hi, Lo}, 64'd63);
        chk("ignored-start result", 64'(ALUResult), 64'(63));
        tick();
        chk("ignored-start no restart", 64'(Busy), 64'(0));

        // Reset in the middle of a multiply aborts it
        Start = 1'b1; ALUControl = OP_MULTU; A = 32'h1234; B = 32'h10;
        tick();
        Start = 1'b0;
        dcnt = 0;
        for (c = 1; c < 10; c++) begin
            if (c == 5) begin
                Start = 1'b1; ALUControl = OP_ADD; A = 32'd1; B = 32'd2;
            end else begin
                Start = 1'b0;
            end
            if (Done) dcnt++;
            tick();
        end
        Start = 1'b0;
        chk("midop busy before reset", 64'(Busy), 64'(1));
        Reset = 1'b1;
        #1;
        chk("midop reset busy", 64'(Busy), 64'(0));
        chk("midop reset hilo", {Hi, Lo}, 64'd0);
        chk("midop reset result", 64'(ALUResult), 64'(0));
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (Done) dcnt++;
        end
        chk("midop no done", 64'(dcnt), 64'(0));
        chk("midop idle after reset", 64'(Busy), 64'(0));
        #1;

        fresh.op = OP_MULTU; fresh.a = 32'hFFFFFFFF; fresh.b = 32'h00000002;
        fresh.res = 32'hFFFFFFFE; fresh.hi = 32'h00000001; fresh.lo = 32'hFFFFFFFE;
        fresh.lat = 34; fresh.dbz = 1'b0;
        run_vec(fresh, 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
